iterative_alu: RTL and testbench

- Per-thread arithmetic unit that consumes the register file's rs/rt operand outputs and produces alu_out for the register file's ARITHMETIC write-back path.
- ADD/SUB/CMP complete in one cycle; MUL (shift-add) and DIV (restoring) are iterative, one bit per clock.
- Exposes an IDLE/BUSY/DONE status, so the core scheduler holds in WAIT until no thread's unit is BUSY.
- One instance per thread, alongside that thread's register file.

---
 rtl/iterative_alu.sv | 129 ++++++++++++
 tb/tb_iterative_alu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Per-thread ALU: ADD/SUB/CMP in one cycle, MUL (shift-add) and DIV (restoring)
// one bit per clock, with an IDLE/BUSY/DONE handshake toward the scheduler.
module iterative_alu #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_alu_enable,
    input  logic [1:0]           decoded_alu_arithmetic_mux,
    input  logic                 decoded_alu_output_mux,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic [1:0]           alu_state,
    output logic [DATA_BITS-1:0] alu_out
);
    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [2:0] CORE_WAIT   = 3'b100;
    localparam logic [2:0] CORE_UPDATE = 3'b110;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier.
    // DIV: acc = partial remainder, opa = dividend becoming quotient, opb = divisor.
    logic [DATA_BITS-1:0] acc, opa, opb;
    logic [CNT_W-1:0]     counter;
    logic                 is_div;

    logic                 start, start_iter, last_iter;
    logic [DATA_BITS-1:0] single_res;
    logic [DATA_BITS-1:0] acc_step, opa_step, opb_step, iter_res;
    logic [DATA_BITS:0]   div_shifted, div_trial;

    assign start      = (state == IDLE) && (core_state == CORE_WAIT) && decoded_alu_enable;
    assign start_iter = start && !decoded_alu_output_mux &&
                        ((decoded_alu_arithmetic_mux == OP_MUL) ||
                         ((decoded_alu_arithmetic_mux == OP_DIV) && (rt != '0)));
    assign last_iter  = (counter == CNT_W'(DATA_BITS - 1));
    assign alu_state  = state;

    always_comb begin
        single_res = '0;
        if (decoded_alu_output_mux) begin
            single_res[2] = (rs > rt);
            single_res[1] = (rs == rt);
            single_res[0] = (rs < rt);
        end else begin
            case (decoded_alu_arithmetic_mux)
                OP_ADD:  single_res = rs + rt;
                OP_SUB:  single_res = rs - rt;
                default: single_res = '1;  // only DIV by zero completes here
            endcase
        end
    end

    // Trial subtraction sign lives in the extra MSB of div_trial.
    assign div_shifted = {acc, opa[DATA_BITS-1]};
    assign div_trial   = div_shifted - {1'b0, opb};

    always_comb begin
        acc_step = '0;
        opa_step = '0;
        opb_step = '0;
        if (is_div) begin
            opb_step = opb;
            if (!div_trial[DATA_BITS]) begin
                acc_step = div_trial[DATA_BITS-1:0];
                opa_step = {opa[DATA_BITS-2:0], 1'b1};
            end else begin
                acc_step = div_shifted[DATA_BITS-1:0];
                opa_step = {opa[DATA_BITS-2:0], 1'b0};
            end
        end else begin
            acc_step = acc + (opb[0] ? opa : '0);
            opa_step = opa << 1;
            opb_step = opb >> 1;
        end
        iter_res = is_div ? opa_step : acc_step;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = start_iter ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (core_state == CORE_UPDATE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            alu_out <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            counter <= '0;
            is_div  <= 1'b0;
        end else if (enable) begin
            state <= state_next;
            if (start) begin
                opa     <= rs;
                opb     <= rt;
                acc     <= '0;
                counter <= '0;
                is_div  <= (decoded_alu_arithmetic_mux == OP_DIV);
                if (!start_iter) alu_out <= single_res;
            end else if (state == BUSY) begin
                acc     <= acc_step;
                opa     <= opa_step;
                opb     <= opb_step;
                counter <= counter + 1'b1;
                if (last_iter) alu_out <= iter_res;
            end
        end
    end
endmodule

// File: tb/tb_iterative_alu.sv
// Directed + random checks of iterative_alu against an arithmetic reference
// model covering result values, BUSY duration, stalls, reset abort and UPDATE.
module tb_iterative_alu;
    localparam logic [2:0] REQUEST = 3'b011, WAIT = 3'b100, UPDATE = 3'b110;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10;

    logic       clk = 1'b0;
    logic       reset, enable, decoded_alu_enable, decoded_alu_output_mux;
    logic [2:0] core_state;
    logic [1:0] decoded_alu_arithmetic_mux, alu_state;
    logic [7:0] rs, rt, alu_out;

    int tests = 0;
    int failed = 0;

    iterative_alu #(.DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_alu_enable(decoded_alu_enable),
        .decoded_alu_arithmetic_mux(decoded_alu_arithmetic_mux),
        .decoded_alu_output_mux(decoded_alu_output_mux),
        .rs(rs), .rt(rt), .alu_state(alu_state), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [1:0] op, input logic cmp, input int a, input int b);
        if (cmp) return ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
        case (op)
            ADD: return (a + b) % 256;
            SUB: return (a - b + 256) % 256;
            MUL: return (a * b) % 256;
            default: return (b == 0) ? 255 : a / b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start an op in WAIT, scramble operands, optionally stall, then confirm
    // DONE holds through WAIT and clears on UPDATE with the result held.
    task automatic run_op(input logic [1:0] op, input logic cmp, input int a, input int b,
                          input int stall_at, input int stall_len, input string tag);
        int  exp, edges;
        bit  iter;
        exp  = model(op, cmp, a, b);
        iter = !cmp && (op == MUL || (op == DIV && b != 0));
        core_state = WAIT; decoded_alu_enable = 1'b1;
        decoded_alu_arithmetic_mux = op; decoded_alu_output_mux = cmp;
        rs = 8'(a); rt = 8'(b);
        tick();
        rs = 8'd0; rt = 8'd0; core_state = REQUEST; decoded_alu_enable = 1'b0;
        if (iter) begin
            check({tag, " busy_after_start"}, alu_state, S_BUSY);
            edges = 0;
            while (alu_state == S_BUSY && edges < 40) begin
                if (edges == stall_at) begin
                    enable = 1'b0;
                    repeat (stall_len) begin
                        tick();
                        edges++;
                    end
                    check({tag, " busy_while_stalled"}, alu_state, S_BUSY);
                    enable = 1'b1;
                end
                tick();
                edges++;
            end
            check({tag, " busy_edges"}, edges, 8 + stall_len);
        end
        check({tag, " done_state"}, alu_state, S_DONE);
        check({tag, " result"}, alu_out, exp);
        core_state = WAIT; decoded_alu_enable = 1'b1;
        decoded_alu_arithmetic_mux = ADD; decoded_alu_output_mux = 1'b0;
        rs = 8'd1; rt = 8'd1;
        tick();
        check({tag, " no_restart_state"}, alu_state, S_DONE);
        check({tag, " no_restart_out"}, alu_out, exp);
        core_state = UPDATE; decoded_alu_enable = 1'b0;
        tick();
        check({tag, " update_idle"}, alu_state, S_IDLE);
        check({tag, " update_held"}, alu_out, exp);
        core_state = REQUEST;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = REQUEST;
        decoded_alu_enable = 1'b0; decoded_alu_arithmetic_mux = ADD;
        decoded_alu_output_mux = 1'b0; rs = 8'd0; rt = 8'd0;
        tick(); tick();
        check("reset_state", alu_state, S_IDLE);
        check("reset_out", alu_out, 0);
        reset = 1'b0;
        tick();

        core_state = WAIT; decoded_alu_enable = 1'b0;
        tick();
        check("wait_no_enable_idle", alu_state, S_IDLE);
        core_state = REQUEST;

        run_op(ADD, 1'b0, 200, 100, -1, 0, "add_200_100");
        run_op(SUB, 1'b0, 3, 5, -1, 0, "sub_3_5");
        run_op(ADD, 1'b1, 5, 9, -1, 0, "cmp_5_9");
        run_op(MUL, 1'b1, 9, 9, -1, 0, "cmp_9_9");
        run_op(SUB, 1'b1, 200, 7, -1, 0, "cmp_200_7");
        run_op(MUL, 1'b0, 13, 11, -1, 0, "mul_13_11");
        run_op(MUL, 1'b0, 20, 20, -1, 0, "mul_20_20");
        run_op(DIV, 1'b0, 100, 7, -1, 0, "div_100_7");
        run_op(DIV, 1'b0, 100, 0, -1, 0, "div_100_0");
        run_op(DIV, 1'b0, 255, 1, -1, 0, "div_255_1");
        run_op(MUL, 1'b0, 13, 11, 3, 3, "mul_stall");

        // Reset mid-MUL aborts; a fresh ADD then works normally.
        core_state = WAIT; decoded_alu_enable = 1'b1;
        decoded_alu_arithmetic_mux = MUL; decoded_alu_output_mux = 1'b0;
        rs = 8'd13; rt = 8'd11;
        tick();
        core_state = REQUEST; decoded_alu_enable = 1'b0;
        tick(); tick();
        check("mid_mul_busy", alu_state, S_BUSY);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_idle", alu_state, S_IDLE);
        check("abort_out", alu_out, 0);
        run_op(ADD, 1'b0, 1, 1, -1, 0, "add_after_reset");

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic       cmp;
            int         a, b;
            op  = 2'($urandom_range(0, 3));
            cmp = ($urandom_range(0, 3) == 0);
            a   = $urandom_range(0, 255);
            b   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            run_op(op, cmp, a, b, -1, 0, $sformatf("rand%0d_op%0d_c%0d_%0d_%0d", i, op, cmp, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
